// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier and its saturation stage.
package mul_pkg;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    localparam int unsigned MAX_W = 64;

    // Caller sign- or zero-extends v to MAX_W; neg selects whether to negate.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_umax(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/mul_sat_clamp.sv
// Combinational clamp of an (A_W+B_W)-bit product into Y_W bits, signed or unsigned.
module mul_sat_clamp
    import mul_pkg::*;
#(
    parameter int unsigned A_W = 8,
    parameter int unsigned B_W = 4,
    parameter int unsigned Y_W = 8
) (
    input  logic [A_W+B_W-1:0] i_p,
    input  logic               i_is_signed,
    output logic [Y_W-1:0]     o_y,
    output logic               o_ovf
);

    localparam int unsigned P_W = A_W + B_W;

    if (Y_W >= P_W) begin : g_nosat
        always_comb begin
            o_y            = {Y_W{i_is_signed & i_p[P_W-1]}};
            o_y[P_W-1:0]   = i_p;
            o_ovf          = 1'b0;
        end
    end else begin : g_sat
        localparam logic [Y_W-1:0] UMAX = Y_W'(sat_umax(Y_W));
        localparam logic [Y_W-1:0] SMAX = Y_W'(sat_smax(Y_W));
        localparam logic [Y_W-1:0] SMIN = Y_W'(sat_smin(Y_W));

        logic [P_W-Y_W:0] w_hi;
        logic             w_fit_s;
        logic             w_fit_u;

        // Signed value fits when every bit from the result sign bit upward agrees.
        assign w_hi    = i_p[P_W-1:Y_W-1];
        assign w_fit_s = (&w_hi) | ~(|w_hi);
        assign w_fit_u = ~(|i_p[P_W-1:Y_W]);

        always_comb begin
            o_y   = i_p[Y_W-1:0];
            o_ovf = 1'b0;
            if (i_is_signed) begin
                if (!w_fit_s) begin
                    o_ovf = 1'b1;
                    o_y   = i_p[P_W-1] ? SMIN : SMAX;
                end
            end else if (!w_fit_u) begin
                o_ovf = 1'b1;
                o_y   = UMAX;
            end
        end
    end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, saturated result.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned A_W = 8,
    parameter int unsigned B_W = 4,
    parameter int unsigned Y_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    input  logic           i_is_signed,
    output logic           o_ready,
    output logic           o_busy,
    output logic           o_done,
    output logic [Y_W-1:0] o_y,
    output logic           o_ovf
);

    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned CNT_W = $clog2(B_W + 1);

    state_t r_state;
    state_t w_state_next;

    logic             r_neg;
    logic             r_is_signed;
    logic [P_W-1:0]   r_mcand;
    logic [P_W-1:0]   r_acc;
    logic [B_W-1:0]   r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [Y_W-1:0]   r_y;
    logic             r_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [P_W-1:0]   w_a_mag;
    logic [B_W-1:0]   w_b_mag;
    logic [P_W-1:0]   w_acc_next;
    logic [P_W-1:0]   w_mcand_next;
    logic [B_W-1:0]   w_mplier_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;
    logic [P_W-1:0]   w_p;
    logic [Y_W-1:0]   w_y;
    logic             w_ovf;

    assign w_accept = (r_state == IDLE) & i_start;
    assign w_a_neg  = i_is_signed & i_a[A_W-1];
    assign w_b_neg  = i_is_signed & i_b[B_W-1];

    // Magnitude of the most negative operand still fits as an unsigned value of its width.
    assign w_a_mag = P_W'(abs_val({{(MAX_W-A_W){w_a_neg}}, i_a}, w_a_neg));
    assign w_b_mag = B_W'(abs_val({{(MAX_W-B_W){w_b_neg}}, i_b}, w_b_neg));

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mcand_next  = r_mcand << 1;
    assign w_mplier_next = r_mplier >> 1;
    assign w_cnt_next    = r_cnt - CNT_W'(1);

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == CNT_W'(1));
`endif

    assign w_p = r_neg ? (~w_acc_next + P_W'(1)) : w_acc_next;

    mul_sat_clamp #(
        .A_W (A_W),
        .B_W (B_W),
        .Y_W (Y_W)
    ) u_clamp (
        .i_p         (w_p),
        .i_is_signed (r_is_signed),
        .o_y         (w_y),
        .o_ovf       (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_last)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == IDLE);
        o_busy  = (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_neg       <= 1'b0;
            r_is_signed <= 1'b0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_neg       <= w_a_neg ^ w_b_neg;
                r_is_signed <= i_is_signed;
                r_mcand     <= w_a_mag;
                r_acc       <= '0;
                r_mplier    <= w_b_mag;
                r_cnt       <= CNT_W'(B_W);
            end else if (r_state == RUN) begin
                r_acc    <= w_acc_next;
                r_mcand  <= w_mcand_next;
                r_mplier <= w_mplier_next;
                r_cnt    <= w_cnt_next;
                if (w_last) begin
                    r_y    <= w_y;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_y    = r_y;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench for seq_shift_add_mul: directed cases, handshake/reset corners, random ops.
module tb_seq_shift_add_mul;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_a = '0;
    logic [3:0] i_b = '0;
    logic       i_is_signed = 1'b0;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_y;
    logic       o_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] y;
        logic       ovf;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    seq_shift_add_mul #(
        .A_W (8),
        .B_W (4),
        .Y_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_is_signed (i_is_signed),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_y         (o_y),
        .o_ovf       (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer product, clamp to the result range, latency from multiplier size.
    task automatic model(input logic [7:0] a, input logic [3:0] b, input logic s,
                         output logic [7:0] y, output logic ovf, output int lat);
        int p;
        int hi;
        int lo;
        int mb;
        int tmp;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        hi  = s ? 127 : 255;
        lo  = s ? -128 : 0;
        ovf = 1'b1;
        if (p > hi)      y = 8'(hi);
        else if (p < lo) y = 8'(lo);
        else begin
            y   = 8'(p);
            ovf = 1'b0;
        end
`ifdef SEQ_MUL_EARLY_TERM_EN
        mb = int'(b);
        if (s && b[3]) mb = 16 - mb;
        tmp = mb;
        lat = 0;
        do begin
            tmp = tmp >> 1;
            lat++;
        end while (tmp != 0 && lat < 4);
`else
        mb  = 0;
        tmp = mb;
        lat = 4 + tmp;
`endif
    endtask

    always @(negedge clk) begin
        if (reset && o_done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done with y=%0h ovf=%0b, required no done",
                         o_y, o_ovf);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({"y ", e.tag}, 32'(o_y), 32'(e.y));
                check({"ovf ", e.tag}, 32'(o_ovf), 32'(e.ovf));
                check({"latency ", e.tag}, edge_cnt, e.cyc);
                check({"ready_in_done ", e.tag}, 32'(o_ready), 32'd1);
            end
        end
    end

    // Must be called at a negedge where the DUT is ready.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic s, input bit push);
        exp_t e;
        int   lat;
        i_a         = a;
        i_b         = b;
        i_is_signed = s;
        i_start     = 1'b1;
        model(a, b, s, e.y, e.ovf, lat);
        e.cyc = edge_cnt + 1 + lat;
        e.tag = $sformatf("(a=%0h b=%0h s=%0b)", a, b, s);
        if (push) sb.push_back(e);
        @(negedge clk);
        i_start     = 1'b0;
        i_a         = 8'($urandom);
        i_b         = 4'($urandom);
        i_is_signed = 1'($urandom);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] d_a [10] = '{8'd13, 8'd200, 8'hFD, 8'h80, 8'h7F, 8'd0, 8'd5, 8'd1, 8'd7, 8'hFF};
        logic [3:0] d_b [10] = '{4'd5, 4'd15, 4'h5, 4'h8, 4'hC, 4'd9, 4'd0, 4'd1, 4'd4, 4'hF};
        logic       d_s [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check("reset ready", 32'(o_ready), 32'd1);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset y", 32'(o_y), 32'd0);
        check("reset ovf", 32'(o_ovf), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Consecutive issues start in each done cycle, exercising back-to-back acceptance.
        for (int i = 0; i < 10; i++) begin
            wait_ready();
            issue(d_a[i], d_b[i], d_s[i], 1'b1);
        end

        wait_ready();
        issue(8'd9, 4'd7, 1'b0, 1'b1);
        i_a         = 8'hFF;
        i_b         = 4'hF;
        i_is_signed = 1'b0;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;

        wait_ready();
        @(negedge clk);
        issue(8'h55, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_reset ready", 32'(o_ready), 32'd1);
        check("midrun_reset busy", 32'(o_busy), 32'd0);
        check("midrun_reset y", 32'(o_y), 32'd0);
        check("midrun_reset ovf", 32'(o_ovf), 32'd0);
        check("midrun_reset done", 32'(o_done), 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            wait_ready();
            issue(8'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        end

        wait_ready();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
